// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register family.
package pipe_pkg;

    // Deepest pipe the occupancy counter is sized for.
    localparam int PIPE_MAX_DEPTH = 8;

    // Width of the occupancy count; holds 0..PIPE_MAX_DEPTH.
    localparam int OCC_W = 4;

    // Standard writeback control bundle carried alongside a payload.
    typedef struct packed {
        logic       load;
        logic       reg_write;
        logic [4:0] rd;
    } wb_ctrl_t;

    // Control width to use when the stage carries a full wb_ctrl_t.
    localparam int WB_CTRL_W = $bits(wb_ctrl_t);

    // Position in the ready vector of the ready that stage 'stage' sees from downstream.
    function automatic int rdy_idx(input int stage);
        return stage + 1;
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One elastic pipeline slot: valid/ctrl/data register with load, flush and ctrl gating.
module pipe_stage_cell
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic              nextValid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next state: flush kills valid and ctrl but leaves data alone; otherwise load or hold.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = valid_i;
            ctrl_d  = valid_i ? ctrl_i : '0;
            data_d  = data_i;
        end
    end

    // Slot register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o     = valid_q;
    assign nextValid_o = valid_d;
    assign ctrl_o      = valid_q ? ctrl_q : '0;
    assign data_o      = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// DEPTH-stage elastic pipeline register with ready/valid backpressure, flush and ctrl gating.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    logic [DEPTH:0]    rdy;
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  nextValid;
    logic [CTRL_W-1:0] stageCtrl [DEPTH];
    logic [DATA_W-1:0] stageData [DEPTH];

    logic              downReady;
    logic [OCC_W-1:0]  occCount_q, occCount_d;

    // Ready chain from the output back to the input: a stage is ready when empty or when the stage below is ready.
    always_comb begin
        rdy            = '0;
        rdy[DEPTH]     = out_ready;
        downReady      = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            downReady = ~valid[i] | downReady;
            rdy[i]    = downReady;
        end
    end

    assign in_ready = rdy[0];

    // One cell per stage; stage 0 takes the input, later stages take the stage above.
    for (genvar g = 0; g < DEPTH; g++) begin : gStage
        logic              srcValid;
        logic [CTRL_W-1:0] srcCtrl;
        logic [DATA_W-1:0] srcData;

        if (g == 0) begin : gHead
            assign srcValid = in_valid;
            assign srcCtrl  = in_ctrl;
            assign srcData  = in_data;
        end else begin : gBody
            assign srcValid = valid[g-1];
            assign srcCtrl  = stageCtrl[g-1];
            assign srcData  = stageData[g-1];
        end

        pipe_stage_cell #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) uCell (
            .clk         (clk),
            .rst         (rst),
            .load_i      (rdy[g]),
            .flush_i     (flush),
            .valid_i     (srcValid),
            .ctrl_i      (srcCtrl),
            .data_i      (srcData),
            .valid_o     (valid[g]),
            .nextValid_o (nextValid[g]),
            .ctrl_o      (stageCtrl[g]),
            .data_o      (stageData[g])
        );
    end

    assign out_valid = valid[DEPTH-1];
    assign out_ctrl  = stageCtrl[DEPTH-1];
    assign out_data  = stageData[DEPTH-1];

    // Popcount of the valid bits the stages will hold after this edge.
    always_comb begin
        occCount_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occCount_d = occCount_d + OCC_W'(nextValid[i]);
        end
    end

    // Occupancy register, updated on the same edge as the valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occCount_q <= '0;
        end else begin
            occCount_q <= occCount_d;
        end
    end

    assign occupancy = occCount_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stallCnt_q;
    logic [31:0] bubbleCnt_q;
    logic [15:0] flushCnt_q;

    // Free-running wrap-around event counters; only reset clears them, flush does not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_q  <= '0;
            bubbleCnt_q <= '0;
            flushCnt_q  <= '0;
        end else begin
            if (out_valid & ~out_ready) begin
                stallCnt_q <= stallCnt_q + 32'd1;
            end
            if (~out_valid) begin
                bubbleCnt_q <= bubbleCnt_q + 32'd1;
            end
            if (flush) begin
                flushCnt_q <= flushCnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt  = stallCnt_q;
    assign bubble_cnt = bubbleCnt_q;
    assign flush_cnt  = flushCnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomized and directed bench for pipe_stage_elastic (DEPTH=3) against a slot-level reference model.
module tb_pipe_stage_elastic;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;
    localparam int DEPTH  = 3;
    localparam int LAST   = DEPTH - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
    logic [15:0]       flush_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model: each slot either holds a beat or is empty; accepted beats also go into a FIFO.
    bit                mValid [DEPTH];
    logic [CTRL_W-1:0] mCtrl  [DEPTH];
    logic [DATA_W-1:0] mData  [DEPTH];
    logic [DATA_W-1:0] sbQ    [$];
    int unsigned       mStall, mBubble, mFlush;

    pipe_stage_elastic #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // A beat can enter if any slot is empty or the output is being drained.
    function automatic bit modelInReady();
        for (int j = 0; j < DEPTH; j++) begin
            if (!mValid[j]) return 1'b1;
        end
        return out_ready;
    endfunction

    function automatic int modelOcc();
        int n = 0;
        for (int j = 0; j < DEPTH; j++) n += int'(mValid[j]);
        return n;
    endfunction

    function automatic logic [CTRL_W-1:0] modelOutCtrl();
        return mValid[LAST] ? mCtrl[LAST] : '0;
    endfunction

    task automatic modelReset();
        for (int j = 0; j < DEPTH; j++) begin
            mValid[j] = 1'b0;
            mCtrl[j]  = '0;
            mData[j]  = '0;
        end
        sbQ.delete();
        mStall  = 0;
        mBubble = 0;
        mFlush  = 0;
    endtask

    // Advance the model one clock edge using the inputs that were stable across it.
    task automatic modelStep();
        bit adv [DEPTH];
        bit hole = 1'b0;
        for (int i = LAST; i >= 0; i--) begin
            hole   = hole | !mValid[i];
            adv[i] = hole | out_ready;
        end
        if (mValid[LAST] && !out_ready) mStall++;
        if (!mValid[LAST]) mBubble++;
        if (flush) mFlush++;
        if (mValid[LAST] && out_ready && sbQ.size() > 0) void'(sbQ.pop_front());
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mValid[i] = 1'b0;
                mCtrl[i]  = '0;
            end
            sbQ.delete();
        end else begin
            for (int i = LAST; i >= 1; i--) begin
                if (adv[i]) begin
                    mValid[i] = mValid[i-1];
                    mCtrl[i]  = mCtrl[i-1];
                    mData[i]  = mData[i-1];
                end
            end
            if (adv[0]) begin
                mValid[0] = in_valid;
                mCtrl[0]  = in_ctrl;
                mData[0]  = in_data;
                if (in_valid) sbQ.push_back(in_data);
            end
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                                 input bit ordy, input bit fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // One clock: model follows the edge, then outputs settle until the falling edge.
    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic pulseReset();
        #1 rst = 1'b1;
        #1;
        modelReset();
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 4'hA, 32'hDEAD_BEEF, 1'b0, 1'b0);
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        compared++;
        if (out_ctrl !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_out_ctrl: got %h want 0", out_ctrl); end
        compared++;
        if (out_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
        compared++;
        if (occupancy !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_occupancy: got %0d want 0", occupancy); end
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_throughput();
        int expOcc;
        for (int c = 1; c <= 7; c++) begin
            applyStimulus(c <= 5, 4'h1, DATA_W'(c), 1'b1, 1'b0);
            tick();
            expOcc = (c <= 3) ? c : ((c <= 5) ? 3 : 8 - c);
            compared++;
            if (occupancy !== 4'(expOcc)) begin
                mismatched++; $display("[TB] FAIL thru_occupancy c=%0d: got %0d want %0d", c, occupancy, expOcc);
            end
            if (c >= 3) begin
                compared++;
                if (out_valid !== 1'b1 || out_data !== DATA_W'(c - 2)) begin
                    mismatched++;
                    $display("[TB] FAIL thru_out c=%0d: got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, c - 2);
                end
            end
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        for (int k = 0; k < DEPTH; k++) tick();
    endtask

    task automatic test_backpressure();
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b1, 4'h2, DATA_W'(c), 1'b0, 1'b0);
            tick();
        end
        compared++;
        if (occupancy !== 4'd3) begin mismatched++; $display("[TB] FAIL bp_fill_occ: got %0d want 3", occupancy); end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 4'h2, 32'h4, 1'b0, 1'b0);
            #1;
            compared++;
            if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_in_ready k=%0d: got %b want 0", k, in_ready); end
            tick();
            compared++;
            if (out_valid !== 1'b1 || out_data !== 32'h1) begin
                mismatched++; $display("[TB] FAIL bp_hold k=%0d: got v=%b d=%h want v=1 d=1", k, out_valid, out_data);
            end
        end
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
            #1;
            compared++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(k)) begin
                mismatched++; $display("[TB] FAIL bp_release k=%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, k);
            end
            tick();
        end
        compared++;
        if (out_valid !== 1'b0 || occupancy !== 4'd0) begin
            mismatched++; $display("[TB] FAIL bp_drained: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
    endtask

    task automatic test_ctrl_gating();
        applyStimulus(1'b1, 4'hF, 32'hAA, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 4'hF, 32'hAA, 1'b1, 1'b0);
        tick();
        tick();
        compared++;
        if (out_valid !== 1'b1 || out_ctrl !== 4'hF) begin
            mismatched++; $display("[TB] FAIL gate_beat: got v=%b ctrl=%h want v=1 ctrl=f", out_valid, out_ctrl);
        end
        tick();
        compared++;
        if (out_valid !== 1'b0 || out_ctrl !== 4'h0) begin
            mismatched++; $display("[TB] FAIL gate_bubble: got v=%b ctrl=%h want v=0 ctrl=0", out_valid, out_ctrl);
        end
        compared++;
        if (out_data !== 32'hAA) begin mismatched++; $display("[TB] FAIL gate_stale_data: got %h want aa", out_data); end
    endtask

    task automatic test_flush();
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b1, 4'h5, DATA_W'(c * 17), 1'b0, 1'b0);
            tick();
        end
        compared++;
        if (occupancy !== 4'd3) begin mismatched++; $display("[TB] FAIL flush_fill_occ: got %0d want 3", occupancy); end
        applyStimulus(1'b1, 4'h7, 32'h77, 1'b1, 1'b1);
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_in_ready: got %b want 1", in_ready); end
        tick();
        compared++;
        if (out_valid !== 1'b0 || occupancy !== 4'd0 || out_ctrl !== 4'h0) begin
            mismatched++;
            $display("[TB] FAIL flush_clear: got v=%b occ=%0d ctrl=%h want 0/0/0", out_valid, occupancy, out_ctrl);
        end
        compared++;
        if (out_data !== 32'h11) begin mismatched++; $display("[TB] FAIL flush_data_kept: got %h want 11", out_data); end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            compared++;
            if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_no_emerge k=%0d: got v=%b want 0", k, out_valid); end
        end
    endtask

    task automatic test_bubble_collapse();
        applyStimulus(1'b1, 4'h3, 32'hB1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h3, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'h3, 32'hB2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bubble_in_ready: got %b want 1", in_ready); end
        tick();
        compared++;
        if (occupancy !== 4'd2 || out_data !== 32'hB1) begin
            mismatched++; $display("[TB] FAIL bubble_hold: got occ=%0d d=%h want occ=2 d=b1", occupancy, out_data);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        compared++;
        if (out_valid !== 1'b1 || out_data !== 32'hB2) begin
            mismatched++; $display("[TB] FAIL bubble_order: got v=%b d=%h want v=1 d=b2", out_valid, out_data);
        end
        tick();
        tick();
    endtask

    task automatic test_mid_reset();
        applyStimulus(1'b1, 4'h9, 32'h55, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        pulseReset();
        compared++;
        if (out_valid !== 1'b0 || occupancy !== 4'd0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midreset: got v=%b occ=%0d d=%h rdy=%b want 0/0/0/1", out_valid, occupancy, out_data, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf_counters();
        pulseReset();
        rst = 1'b0;
        compared++;
        if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0 || flush_cnt !== 16'd0) begin
            mismatched++; $display("[TB] FAIL perf_reset0: got %0d/%0d/%0d want 0/0/0", stall_cnt, bubble_cnt, flush_cnt);
        end
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b1, 4'h1, DATA_W'(c), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        compared++;
        if (stall_cnt !== 32'd5 || flush_cnt !== 16'd1 || bubble_cnt !== 32'(mBubble)) begin
            mismatched++;
            $display("[TB] FAIL perf_counts: got s=%0d b=%0d f=%0d want s=5 b=%0d f=1", stall_cnt, bubble_cnt, flush_cnt, mBubble);
        end
        pulseReset();
        compared++;
        if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0 || flush_cnt !== 16'd0) begin
            mismatched++; $display("[TB] FAIL perf_reset1: got %0d/%0d/%0d want 0/0/0", stall_cnt, bubble_cnt, flush_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 3) != 0), CTRL_W'($urandom), DATA_W'($urandom),
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
            #1;
            compared++;
            if (in_ready !== modelInReady() || out_valid !== mValid[LAST] || out_ctrl !== modelOutCtrl()
                || occupancy !== 4'(modelOcc()) || (mValid[LAST] && out_data !== mData[LAST])) begin
                mismatched++;
                errs++;
                if (errs <= 10)
                    $display("[TB] FAIL rand_state n=%0d: got rdy=%b v=%b ctrl=%h occ=%0d d=%h want rdy=%b v=%b ctrl=%h occ=%0d d=%h",
                             n, in_ready, out_valid, out_ctrl, occupancy, out_data,
                             modelInReady(), mValid[LAST], modelOutCtrl(), modelOcc(), mData[LAST]);
            end
            if (out_valid === 1'b1 && out_ready) begin
                compared++;
                if (sbQ.size() == 0 || out_data !== sbQ[0]) begin
                    mismatched++;
                    errs++;
                    if (errs <= 10)
                        $display("[TB] FAIL rand_order n=%0d: got %h want %h (queued %0d)", n, out_data,
                                 (sbQ.size() > 0) ? sbQ[0] : 'x, sbQ.size());
                end
            end
            tick();
        end
`ifdef PIPE_STAGE_PERF_EN
        compared++;
        if (stall_cnt !== 32'(mStall) || bubble_cnt !== 32'(mBubble) || flush_cnt !== 16'(mFlush)) begin
            mismatched++;
            $display("[TB] FAIL rand_perf: got %0d/%0d/%0d want %0d/%0d/%0d", stall_cnt, bubble_cnt, flush_cnt,
                     mStall, mBubble, mFlush);
        end
`endif
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        test_reset();
        test_throughput();
        test_backpressure();
        test_ctrl_gating();
        test_flush();
        test_bubble_collapse();
        test_mid_reset();
`ifdef PIPE_STAGE_PERF_EN
        test_perf_counters();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised successor to the fixed MEM/WB register. It is a DEPTH-stage elastic pipeline register carrying a DATA_W payload and a CTRL_W control field.
- Per-stage valid bits and ready/valid backpressure.
- Synchronous flush, which inserts bubbles.
- Control gating, so a bubble can never assert a write-enable downstream.

It drops in between any two pipeline stages of the core, for example MEM/WB, or EX/MEM with multi-cycle MUL/DIV backpressure.

Parameters:
DATA_W, 64, payload width in bits (e.g. read_data and calculated_result concatenated).
CTRL_W, 4, control width in bits (e.g. load, reg_write, rd-valid); forced to 0 whenever the stage holds a bubble.
DEPTH, 1, number of register stages; legal range 1..8.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream has a valid beat
in_ready  output  1  stage accepts a beat this cycle (combinational)
in_ctrl  input  CTRL_W  upstream control bits
in_data  input  DATA_W  upstream payload
flush  input  1  synchronous kill of all in-flight beats
out_valid  output  1  last stage holds a valid beat
out_ready  input  1  downstream accepts this cycle
out_ctrl  output  CTRL_W  control of last stage, gated by out_valid
out_data  output  DATA_W  payload of last stage
occupancy  output  4  count of valid stages, 0..DEPTH

Behaviour:
- Reset (async, rst=1):
  - Every stage: valid=0, ctrl=0, data=0.
  - Outputs: out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=1 while reset is deasserted and the pipe is empty.
- Ready chain (combinational):
  - rdy[DEPTH]=out_ready.
  - rdy[i] = ~valid[i] | rdy[i+1].
  - in_ready = rdy[0].
  - No combinational path from in_valid to in_ready.
- Stage i load condition: rdy[i]=1 at the clock edge.
  - Stage 0 loads valid<=in_valid, ctrl<=in_ctrl, data<=in_data.
  - Stage i>0 loads from stage i-1.
  - A stage that does not load holds its valid, ctrl and data.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Latency is DEPTH cycles with no backpressure; throughput is 1 beat/cycle.
- Full pipe, all valid, out_ready=0: in_ready=0 and all stages hold. A beat is never dropped or duplicated.
- Bubbles (valid=0) collapse under backpressure: a valid beat advances into a downstream empty stage even while out_ready=0.
- out_ctrl = valid[last] ? ctrl[last] : 0. out_data is driven raw, ungated.
- Flush:
  - At the next edge all valid<=0 and all ctrl<=0. data is left unchanged (power).
  - Flush wins over a simultaneous input transfer: that beat is discarded and in_ready is still reported as computed.
  - Flush during rst: rst dominates.
- occupancy: registered popcount of the valid bits, updated in the same edge as the valid bits.
- rst asserted mid-operation: all state clears immediately (async); no partial beat survives.

Optional Feature:
Macro PIPE_STAGE_PERF_EN. When defined, three extra outputs are present:
- stall_cnt (32): increments each cycle out_valid & ~out_ready.
- bubble_cnt (32): increments each cycle ~out_valid.
- flush_cnt (16): increments each cycle flush=1.

Counter rules:
- All three wrap on overflow, reset to 0 on rst, and are not cleared by flush.

When the macro is not defined, the ports and counters are absent and there is no area cost.

Decomposition:
- Shared package pipe_pkg holds:
  - constants PIPE_MAX_DEPTH=8 and OCC_W=4;
  - a localparam function for the ready-chain index;
  - the typedef for the standard writeback control bundle (load, reg_write, rd[4:0]), so CTRL_W is derived as $bits of it.
- One natural sub-module: pipe_stage_cell, a single valid/ctrl/data register with load, flush and gating. It is instantiated DEPTH times with a generate loop; the parent owns the ready chain, occupancy and counters.

Test Plan:
1. DEPTH=3, out_ready=1, beats data=0x1..0x5 on consecutive cycles -> out_data 0x1..0x5 on cycles 3..7; occupancy steady at 3.
2. DEPTH=3, fill the pipe, then out_ready=0 for 4 cycles -> in_ready=0 and out_data holds 0x1; release -> 0x1,0x2,0x3 in order, no loss or duplicate.
3. DEPTH=2, beat ctrl=4'hF then in_valid=0 -> out_ctrl=4'hF for one cycle, then 4'h0 while out_data may still show the stale payload.
4. Pipe full (occupancy=2), flush=1 together with in_valid=1 -> next cycle out_valid=0, occupancy=0, out_ctrl=0; the input beat never emerges.
5. DEPTH=3, bubble in stage 1 with out_ready=0 -> stage 0 beat advances into stage 1 and occupancy is unchanged; in_ready=1 that cycle.
6. PIPE_STAGE_PERF_EN defined, 5 cycles of out_valid & ~out_ready plus 1 flush pulse -> stall_cnt=5, flush_cnt=1; assert rst -> all counters read 0.
